// File: rtl/exc_commit_pkg.sv
// exc_commit_pkg: exception codes, composed 7-bit EXP_* codes and commit FSM states
package exc_commit_pkg;
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_TLBR = 6'h3f;
  localparam logic ESUB_NONE = 1'b0;
  localparam logic ESUB_ADEM = 1'b1;
  localparam logic [6:0] EXP_INT  = {ESUB_NONE, ECODE_INT};
  localparam logic [6:0] EXP_PIL  = {ESUB_NONE, ECODE_PIL};
  localparam logic [6:0] EXP_PIS  = {ESUB_NONE, ECODE_PIS};
  localparam logic [6:0] EXP_PIF  = {ESUB_NONE, ECODE_PIF};
  localparam logic [6:0] EXP_PME  = {ESUB_NONE, ECODE_PME};
  localparam logic [6:0] EXP_PPI  = {ESUB_NONE, ECODE_PPI};
  localparam logic [6:0] EXP_ADEF = {ESUB_NONE, ECODE_ADE};
  localparam logic [6:0] EXP_ADEM = {ESUB_ADEM, ECODE_ADE};
  localparam logic [6:0] EXP_ALE  = {ESUB_NONE, ECODE_ALE};
  localparam logic [6:0] EXP_TLBR = {ESUB_NONE, ECODE_TLBR};
  typedef enum logic [1:0] {IDLE, FIRE, DRAIN} state_t;
  function automatic logic badv_code(input logic [5:0] e);
    return e inside {ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME, ECODE_PPI, ECODE_ADE, ECODE_ALE, ECODE_TLBR};
  endfunction
  function automatic logic vppn_code(input logic [5:0] e);
    return badv_code(e) && !(e inside {ECODE_ADE, ECODE_ALE});
  endfunction
endpackage

// File: rtl/exc_commit_select.sv
// exc_select: picks the oldest excepting/ERTN slot and classifies its BADV/VPPN writes
module exc_select
  import exc_commit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              valid0,
  input  logic [ADDR_W-1:0] pc0,
  input  logic              exv0,
  input  logic [6:0]        exp0,
  input  logic [ADDR_W-1:0] badv0,
  input  logic              ertn0,
  input  logic              valid1,
  input  logic [ADDR_W-1:0] pc1,
  input  logic              exv1,
  input  logic [6:0]        exp1,
  input  logic [ADDR_W-1:0] badv1,
  input  logic              ertn1,
  output logic              event_v,
  output logic              exc,
  output logic              ertn,
  output logic [ADDR_W-1:0] pc,
  output logic [6:0]        exp,
  output logic [ADDR_W-1:0] badv,
  output logic              badv_we,
  output logic              vppn_we
);
  logic ev0, ev1;
  assign ev0     = valid0 && (exv0 || ertn0);
  assign ev1     = valid1 && (exv1 || ertn1);
  assign event_v = ev0 || ev1;
  assign exc     = ev0 ? exv0 : ev1 && exv1;
  assign ertn    = event_v && !exc;
  assign pc      = ev0 ? pc0 : pc1;
  assign exp     = ev0 ? exp0 : exp1;
  assign badv    = ev0 ? badv0 : badv1;
  assign badv_we = exc && badv_code(exp[5:0]);
  assign vppn_we = exc && vppn_code(exp[5:0]);
endmodule

// File: rtl/exc_commit.sv
// exc_commit: commit-stage trap/ERTN sequencer; EXC_PERF_CNT_EN adds exception counters
module exc_commit
  import exc_commit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int VPPN_LSB = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid0,
  input  logic [ADDR_W-1:0] commit_pc0,
  input  logic              commit_exv0,
  input  logic [6:0]        commit_exp0,
  input  logic [ADDR_W-1:0] commit_badv0,
  input  logic              commit_ertn0,
  input  logic              commit_valid1,
  input  logic [ADDR_W-1:0] commit_pc1,
  input  logic              commit_exv1,
  input  logic [6:0]        commit_exp1,
  input  logic [ADDR_W-1:0] commit_badv1,
  input  logic              commit_ertn1,
  input  logic [ADDR_W-1:0] csr_eentry,
  input  logic [ADDR_W-1:0] csr_tlbrentry,
  input  logic [ADDR_W-1:0] csr_era,
  input  logic [ADDR_W-1:0] csr_tlbrera,
  input  logic              csr_tlbr_active,
  input  logic              flush_ack,
  output logic              commit_stall,
  output logic              trap_we,
  output logic [5:0]        trap_ecode,
  output logic              trap_esubcode,
  output logic [ADDR_W-1:0] trap_era,
  output logic              trap_is_tlbr,
  output logic              badv_we,
  output logic [ADDR_W-1:0] trap_badv,
  output logic              vppn_we,
  output logic              ertn_we,
  output logic              flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef EXC_PERF_CNT_EN
  ,
  output logic [31:0]       exc_cnt,
  output logic [31:0]       tlb_exc_cnt
`endif
);
  if (VPPN_LSB < 1 || VPPN_LSB >= ADDR_W) begin : g_bad_vppn
    $error("VPPN_LSB out of range");
  end
  state_t state, state_nxt;
  logic sel_event, sel_exc, sel_ertn, sel_badv_we, sel_vppn_we, sel_tlbr, fire, ack_seen;
  logic [ADDR_W-1:0] sel_pc, sel_badv;
  logic [6:0] sel_exp;
  exc_select #(.ADDR_W(ADDR_W)) u_sel (
    .valid0(commit_valid0), .pc0(commit_pc0), .exv0(commit_exv0), .exp0(commit_exp0),
    .badv0(commit_badv0), .ertn0(commit_ertn0),
    .valid1(commit_valid1), .pc1(commit_pc1), .exv1(commit_exv1), .exp1(commit_exp1),
    .badv1(commit_badv1), .ertn1(commit_ertn1),
    .event_v(sel_event), .exc(sel_exc), .ertn(sel_ertn), .pc(sel_pc), .exp(sel_exp),
    .badv(sel_badv), .badv_we(sel_badv_we), .vppn_we(sel_vppn_we)
  );
  assign sel_tlbr     = sel_exp[5:0] == ECODE_TLBR;
  assign fire         = state == IDLE && sel_event;
  assign commit_stall = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // an ack seen during FIRE lets DRAIN exit after a single cycle
  always_comb
    state_nxt = state == IDLE ? (sel_event ? FIRE : IDLE) :
                state == FIRE ? DRAIN :
                (flush_ack || ack_seen) ? IDLE : DRAIN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ack_seen       <= 1'b0;
      trap_we        <= 1'b0;
      ertn_we        <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      badv_we        <= 1'b0;
      vppn_we        <= 1'b0;
      redirect_pc    <= '0;
      trap_ecode     <= '0;
      trap_esubcode  <= 1'b0;
      trap_era       <= '0;
      trap_badv      <= '0;
      trap_is_tlbr   <= 1'b0;
    end else begin
      ack_seen       <= state == FIRE && flush_ack;
      trap_we        <= fire && sel_exc;
      ertn_we        <= fire && sel_ertn;
      flush          <= fire;
      redirect_valid <= fire;
      badv_we        <= fire && sel_badv_we;
      vppn_we        <= fire && sel_vppn_we;
      if (fire)
        redirect_pc <= sel_exc ? (sel_tlbr ? csr_tlbrentry : csr_eentry)
                               : (csr_tlbr_active ? csr_tlbrera : csr_era);
      if (fire && sel_exc) begin
        trap_ecode    <= sel_exp[5:0];
        trap_esubcode <= sel_exp[6];
        trap_era      <= sel_pc;
        trap_badv     <= sel_badv;
        trap_is_tlbr  <= sel_tlbr;
      end
    end
`ifdef EXC_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      exc_cnt     <= '0;
      tlb_exc_cnt <= '0;
    end else begin
      if (trap_we) exc_cnt <= exc_cnt + 32'd1;
      if (vppn_we) tlb_exc_cnt <= tlb_exc_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit: directed and randomized checks of exc_commit against a behavioural model
module tb_exc_commit;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v0, exv0, ertn0, v1, exv1, ertn1;
  logic [AW-1:0] pc0, badv0, pc1, badv1;
  logic [6:0] exp0, exp1;
  logic [AW-1:0] eentry, tlbrentry, era, tlbrera;
  logic tlbr_active, flush_ack;
  logic commit_stall, trap_we, trap_esubcode, trap_is_tlbr, badv_we, vppn_we, ertn_we, flush, redirect_valid;
  logic [5:0] trap_ecode;
  logic [AW-1:0] trap_era, trap_badv, redirect_pc;
`ifdef EXC_PERF_CNT_EN
  logic [31:0] exc_cnt, tlb_exc_cnt;
  int m_exc, m_tlb;
`endif
  int total = 0;
  int bad = 0;
  int badv_codes[8] = '{1, 2, 3, 4, 7, 8, 9, 63};
  int pick_codes[10] = '{0, 1, 2, 3, 4, 7, 8, 9, 63, 13};
  always #5 clk = ~clk;
  exc_commit dut (
    .clk(clk), .rst(rst),
    .commit_valid0(v0), .commit_pc0(pc0), .commit_exv0(exv0), .commit_exp0(exp0),
    .commit_badv0(badv0), .commit_ertn0(ertn0),
    .commit_valid1(v1), .commit_pc1(pc1), .commit_exv1(exv1), .commit_exp1(exp1),
    .commit_badv1(badv1), .commit_ertn1(ertn1),
    .csr_eentry(eentry), .csr_tlbrentry(tlbrentry), .csr_era(era), .csr_tlbrera(tlbrera),
    .csr_tlbr_active(tlbr_active), .flush_ack(flush_ack),
    .commit_stall(commit_stall), .trap_we(trap_we), .trap_ecode(trap_ecode),
    .trap_esubcode(trap_esubcode), .trap_era(trap_era), .trap_is_tlbr(trap_is_tlbr),
    .badv_we(badv_we), .trap_badv(trap_badv), .vppn_we(vppn_we), .ertn_we(ertn_we),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EXC_PERF_CNT_EN
    , .exc_cnt(exc_cnt), .tlb_exc_cnt(tlb_exc_cnt)
`endif
  );
  typedef struct {
    bit ev, exc, tlbr, bwe, vwe, sub;
    bit [5:0] ecode;
    bit [AW-1:0] era, badv, rpc;
  } pred_t;
  function automatic pred_t predict();
    pred_t p;
    int s;
    p = '{default: 0};
    s = (v0 && (exv0 || ertn0)) ? 0 : (v1 && (exv1 || ertn1)) ? 1 : -1;
    if (s < 0) return p;
    p.ev  = 1;
    p.exc = (s == 0) ? exv0 : exv1;
    if (!p.exc) begin
      p.rpc = tlbr_active ? tlbrera : era;
      return p;
    end
    p.ecode = (s == 0) ? exp0[5:0] : exp1[5:0];
    p.sub   = (s == 0) ? exp0[6] : exp1[6];
    p.era   = (s == 0) ? pc0 : pc1;
    p.badv  = (s == 0) ? badv0 : badv1;
    p.tlbr  = p.ecode == 6'h3f;
    foreach (badv_codes[i]) if (badv_codes[i] == int'(p.ecode)) p.bwe = 1;
    p.vwe = p.bwe && p.ecode != 6'h08 && p.ecode != 6'h09;
    p.rpc = p.tlbr ? tlbrentry : eentry;
    return p;
  endfunction
  task automatic clear_slots();
    v0 = 0; exv0 = 0; ertn0 = 0; exp0 = 0; pc0 = 0; badv0 = 0;
    v1 = 0; exv1 = 0; ertn1 = 0; exp1 = 0; pc1 = 0; badv1 = 0;
  endtask
  task automatic pulse_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
`ifdef EXC_PERF_CNT_EN
    m_exc = 0; m_tlb = 0;
`endif
  endtask
  task automatic release_drain();
    @(negedge clk); clear_slots(); flush_ack = 1;
    @(posedge clk); #1;
    @(negedge clk); flush_ack = 0;
  endtask
  task automatic test_reset();
    clear_slots();
    flush_ack = 0; tlbr_active = 0;
    eentry = 32'h1C008000; tlbrentry = 32'h1C00F000; era = 32'h1C000500; tlbrera = 32'h1C000600;
    rst = 1;
    repeat (2) @(negedge clk);
    total++;
    if ({trap_we, ertn_we, flush, redirect_valid, badv_we, vppn_we, commit_stall} !== 7'b0)
      begin bad++; $display("FAIL reset_pulses got=%b want=0", {trap_we, ertn_we, flush, redirect_valid, badv_we, vppn_we, commit_stall}); end
    total++;
    if ({redirect_pc, trap_era, trap_badv, trap_ecode, trap_esubcode, trap_is_tlbr} !== '0)
      begin bad++; $display("FAIL reset_data got pc=%h era=%h badv=%h ec=%h want=0", redirect_pc, trap_era, trap_badv, trap_ecode); end
    rst = 0;
  endtask
  task automatic test_pif();
    @(negedge clk); v0 = 1; exv0 = 1; exp0 = 7'h03; pc0 = 32'h1C000100; badv0 = 32'h1C000100;
    @(posedge clk); #1;
    total++;
    if ({trap_we, badv_we, vppn_we, flush, redirect_valid, ertn_we, trap_is_tlbr} !== 7'b1111100)
      begin bad++; $display("FAIL pif_pulses got=%b want=1111100", {trap_we, badv_we, vppn_we, flush, redirect_valid, ertn_we, trap_is_tlbr}); end
    total++;
    if (trap_ecode !== 6'h03 || redirect_pc !== eentry || trap_era !== 32'h1C000100)
      begin bad++; $display("FAIL pif_data got ec=%h rpc=%h era=%h want 03 %h 1c000100", trap_ecode, redirect_pc, trap_era, eentry); end
    @(negedge clk); clear_slots();
    @(posedge clk); #1;
    total++;
    if (commit_stall !== 1 || flush !== 0 || trap_we !== 0 || trap_badv !== 32'h1C000100)
      begin bad++; $display("FAIL pif_drain got stall=%b flush=%b we=%b badv=%h want 1 0 0 1c000100", commit_stall, flush, trap_we, trap_badv); end
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
      total++;
      if (commit_stall !== 1) begin bad++; $display("FAIL pif_hold got stall=%b want 1", commit_stall); end
    end
    release_drain();
    total++;
    if (commit_stall !== 0) begin bad++; $display("FAIL pif_release got stall=%b want 0", commit_stall); end
  endtask
  task automatic test_tlbr_slot1();
    @(negedge clk); v0 = 1; pc0 = 32'h1C000300;
    v1 = 1; exv1 = 1; exp1 = 7'h3f; pc1 = 32'h1C000304; badv1 = 32'h00ABE000;
    @(posedge clk); #1;
    total++;
    if (trap_is_tlbr !== 1 || redirect_pc !== tlbrentry || trap_era !== 32'h1C000304)
      begin bad++; $display("FAIL tlbr_data got tlbr=%b rpc=%h era=%h want 1 %h 1c000304", trap_is_tlbr, redirect_pc, trap_era, tlbrentry); end
    total++;
    if ({trap_we, badv_we, vppn_we} !== 3'b111 || trap_badv !== 32'h00ABE000)
      begin bad++; $display("FAIL tlbr_we got=%b badv=%h want 111 00abe000", {trap_we, badv_we, vppn_we}, trap_badv); end
    @(negedge clk); clear_slots(); flush_ack = 1;
    @(posedge clk); #1;
    @(negedge clk); flush_ack = 0;
    total++;
    if (commit_stall !== 1) begin bad++; $display("FAIL tlbr_ackfire_drain got stall=%b want 1", commit_stall); end
    @(posedge clk); #1;
    total++;
    if (commit_stall !== 0) begin bad++; $display("FAIL tlbr_ackfire_idle got stall=%b want 0", commit_stall); end
  endtask
  task automatic test_both();
    @(negedge clk); v0 = 1; exv0 = 1; exp0 = 7'h09; pc0 = 32'h1C000400; badv0 = 32'h12345679;
    v1 = 1; exv1 = 1; exp1 = 7'h01; pc1 = 32'h1C000404; badv1 = 32'h55550000;
    @(posedge clk); #1;
    total++;
    if (trap_ecode !== 6'h09 || {badv_we, vppn_we} !== 2'b10 || trap_era !== 32'h1C000400 || trap_badv !== 32'h12345679)
      begin bad++; $display("FAIL both_ale got ec=%h bw=%b vw=%b era=%h badv=%h want 09 1 0", trap_ecode, badv_we, vppn_we, trap_era, trap_badv); end
    release_drain();
  endtask
  task automatic test_ertn();
    @(negedge clk); tlbr_active = 1; tlbrera = 32'h1C002000; era = 32'h1C003000;
    v0 = 1; ertn0 = 1;
    @(posedge clk); #1;
    total++;
    if ({ertn_we, trap_we, flush, redirect_valid, badv_we} !== 5'b10110 || redirect_pc !== 32'h1C002000)
      begin bad++; $display("FAIL ertn got=%b rpc=%h want 10110 1c002000", {ertn_we, trap_we, flush, redirect_valid, badv_we}, redirect_pc); end
    release_drain();
    tlbr_active = 0;
  endtask
  task automatic test_reset_in_drain();
    @(negedge clk); v0 = 1; exv0 = 1; exp0 = 7'h02; pc0 = 32'h1C000500; badv0 = 32'h0000F000;
    @(negedge clk); clear_slots();
    @(posedge clk); #1;
    @(negedge clk); rst = 1;
    #1;
    total++;
    if ({trap_we, flush, redirect_valid, commit_stall, redirect_pc, trap_era, trap_badv, trap_ecode} !== '0)
      begin bad++; $display("FAIL rst_drain got stall=%b rpc=%h era=%h", commit_stall, redirect_pc, trap_era); end
    @(negedge clk); rst = 0;
    v1 = 1; exv1 = 1; exp1 = 7'h04; pc1 = 32'h1C000600; badv1 = 32'h0000A000;
    @(posedge clk); #1;
    total++;
    if (trap_we !== 1 || trap_ecode !== 6'h04 || vppn_we !== 1 || trap_era !== 32'h1C000600)
      begin bad++; $display("FAIL rst_after got we=%b ec=%h vw=%b era=%h want 1 04 1 1c000600", trap_we, trap_ecode, vppn_we, trap_era); end
    release_drain();
  endtask
  task automatic test_drain_ignore();
    pulse_reset();
    @(negedge clk); v0 = 1; exv0 = 1; exp0 = 7'h00; pc0 = 32'h1C000700; badv0 = 32'hDEAD0000;
    @(posedge clk); #1;
    total++;
    if ({trap_we, badv_we, vppn_we} !== 3'b100 || trap_ecode !== 6'h00)
      begin bad++; $display("FAIL int_nobadv got=%b ec=%h want 100 00", {trap_we, badv_we, vppn_we}, trap_ecode); end
    @(negedge clk); v1 = 1; exv1 = 1; exp1 = 7'h48; pc1 = 32'h1C000800;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if ({trap_we, ertn_we, flush, redirect_valid, commit_stall} !== 5'b00001 || trap_era !== 32'h1C000700)
        begin bad++; $display("FAIL drain_ignore got=%b era=%h want 00001 1c000700", {trap_we, ertn_we, flush, redirect_valid, commit_stall}, trap_era); end
      @(negedge clk);
    end
`ifdef EXC_PERF_CNT_EN
    total++;
    if (exc_cnt !== 32'd1 || tlb_exc_cnt !== 32'd0)
      begin bad++; $display("FAIL cnt_once got exc=%0d tlb=%0d want 1 0", exc_cnt, tlb_exc_cnt); end
`endif
    flush_ack = 1;
    @(posedge clk); #1;
    @(negedge clk); flush_ack = 0; clear_slots();
    @(posedge clk); #1;
    total++;
    if (flush !== 0 || commit_stall !== 0)
      begin bad++; $display("FAIL drain_exit got flush=%b stall=%b want 0 0", flush, commit_stall); end
  endtask
  task automatic test_random();
    pred_t p;
    int d;
    pulse_reset();
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      eentry = $urandom; tlbrentry = $urandom; era = $urandom; tlbrera = $urandom;
      tlbr_active = 1'($urandom_range(0, 1));
      v0 = 1'($urandom_range(0, 1)); exv0 = 1'($urandom_range(0, 1)); ertn0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1)); exv1 = 1'($urandom_range(0, 1)); ertn1 = 1'($urandom_range(0, 1));
      exp0 = {1'($urandom_range(0, 1)), 6'(pick_codes[$urandom_range(0, 9)])};
      exp1 = {1'($urandom_range(0, 1)), 6'(pick_codes[$urandom_range(0, 9)])};
      pc0 = $urandom; pc1 = $urandom; badv0 = $urandom; badv1 = $urandom;
      p = predict();
      @(posedge clk); #1;
      if (!p.ev) begin
        total++;
        if ({flush, trap_we, ertn_we, commit_stall} !== 4'b0)
          begin bad++; $display("FAIL rnd_noevent it=%0d got=%b want 0000", it, {flush, trap_we, ertn_we, commit_stall}); end
        continue;
      end
`ifdef EXC_PERF_CNT_EN
      if (p.exc) m_exc++;
      if (p.vwe) m_tlb++;
`endif
      total++;
      if ({trap_we, ertn_we, flush, redirect_valid, badv_we, vppn_we} !== {p.exc, !p.exc, 2'b11, p.bwe, p.vwe})
        begin bad++; $display("FAIL rnd_pulses it=%0d got=%b want=%b", it, {trap_we, ertn_we, flush, redirect_valid, badv_we, vppn_we}, {p.exc, !p.exc, 2'b11, p.bwe, p.vwe}); end
      total++;
      if (redirect_pc !== p.rpc)
        begin bad++; $display("FAIL rnd_rpc it=%0d got=%h want=%h", it, redirect_pc, p.rpc); end
      if (p.exc) begin
        total++;
        if ({trap_ecode, trap_esubcode, trap_era, trap_badv, trap_is_tlbr} !== {p.ecode, p.sub, p.era, p.badv, p.tlbr})
          begin bad++; $display("FAIL rnd_trap it=%0d got ec=%h sub=%b era=%h badv=%h tlbr=%b want %h %b %h %h %b", it, trap_ecode, trap_esubcode, trap_era, trap_badv, trap_is_tlbr, p.ecode, p.sub, p.era, p.badv, p.tlbr); end
      end
      d = $urandom_range(0, 3);
      @(negedge clk); clear_slots(); flush_ack = (d == 0);
      @(posedge clk); #1;
      total++;
      if (commit_stall !== 1 || flush !== 0)
        begin bad++; $display("FAIL rnd_drain it=%0d got stall=%b flush=%b want 1 0", it, commit_stall, flush); end
`ifdef EXC_PERF_CNT_EN
      total++;
      if (exc_cnt !== 32'(m_exc) || tlb_exc_cnt !== 32'(m_tlb))
        begin bad++; $display("FAIL rnd_cnt it=%0d got %0d %0d want %0d %0d", it, exc_cnt, tlb_exc_cnt, m_exc, m_tlb); end
`endif
      repeat (d > 0 ? d - 1 : 0) begin
        @(negedge clk); flush_ack = 0;
        @(posedge clk); #1;
        total++;
        if (commit_stall !== 1) begin bad++; $display("FAIL rnd_hold it=%0d got stall=%b want 1", it, commit_stall); end
      end
      @(negedge clk); flush_ack = (d > 0);
      @(posedge clk); #1;
      total++;
      if (commit_stall !== 0) begin bad++; $display("FAIL rnd_release it=%0d d=%0d got stall=%b want 0", it, d, commit_stall); end
      @(negedge clk); flush_ack = 0;
    end
  endtask
  initial begin
    test_reset();
    test_pif();
    test_tlbr_slot1();
    test_both();
    test_ertn();
    test_reset_in_drain();
    test_drain_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exc_commit.md
Name: exc_commit

Overview:
- Consumer end of the per-slot 7-bit exception codes that the TLB exception logic and the other pipeline checkers produce.
- Sits at the commit stage of the dual-issue pipeline. Selects the oldest excepting or ERTN instruction across two commit slots.
- Drives the trap-time CSR update strobes, the pipeline flush and the fetch redirect.
- Holds commit off until the front end acknowledges the flush.

Parameters:
- ADDR_W, 32, width of PC, BADV and entry addresses
- VPPN_LSB, 13, lowest BADV bit copied to TLBEHI.VPPN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- commit_valid0  in  1  slot0 (older) retiring this cycle
- commit_pc0  in  ADDR_W  slot0 PC
- commit_exv0  in  1  slot0 carries an exception
- commit_exp0  in  7  slot0 code: [6]=esubcode, [5:0]=ecode
- commit_badv0  in  ADDR_W  slot0 faulting address
- commit_ertn0  in  1  slot0 is ERTN
- commit_valid1, commit_pc1, commit_exv1, commit_exp1, commit_badv1, commit_ertn1: slot1 equivalents, same widths
- csr_eentry  in  ADDR_W  general exception entry
- csr_tlbrentry  in  ADDR_W  TLB refill entry
- csr_era  in  ADDR_W  ERA value
- csr_tlbrera  in  ADDR_W  TLBRERA.ERA value
- csr_tlbr_active  in  1  TLBRERA.IsTLBR
- flush_ack  in  1  front end has drained the pipeline
- commit_stall  out  1  commit must hold; inputs ignored
- trap_we  out  1  one-cycle pulse: write ESTAT.Ecode/EsubCode, ERA, PRMD<-CRMD, CRMD.PLV=0/IE=0
- trap_ecode  out  6  ecode latched with trap_we
- trap_esubcode  out  1  esubcode latched with trap_we
- trap_era  out  ADDR_W  PC of the excepting instruction
- trap_is_tlbr  out  1  TLBR trap: write TLBRERA, CRMD.DA=1/PG=0
- badv_we  out  1  write BADV from trap_badv
- trap_badv  out  ADDR_W  faulting address
- vppn_we  out  1  write TLBEHI.VPPN from trap_badv[ADDR_W-1:VPPN_LSB]
- ertn_we  out  1  one-cycle pulse: restore CRMD from PRMD (or TLBRERA path)
- flush  out  1  one-cycle pipeline flush pulse
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_pc  out  ADDR_W  redirect target

Behaviour:
- Reset (async, any state): FSM goes to IDLE. All outputs are 0. commit_stall is 0.
- FSM states and transitions:
  - IDLE: evaluates slots. On an event, goes to FIRE.
  - FIRE: lasts 1 cycle and drives all pulses. Goes to DRAIN.
  - DRAIN: holds until flush_ack=1, then goes to IDLE.
  - commit_stall=1 in FIRE and DRAIN.
- Event selection in IDLE:
  - A slot event is valid && (exv || ertn); exv takes precedence over ertn in the same slot.
  - If slot0 has an event, slot0 is taken and slot1 is ignored.
  - Otherwise slot1 is taken if it has an event.
- Latency: all pulses and data are registered, in the cycle after the commit cycle. Data outputs hold until the next event.
- Exception event:
  - Drives trap_we, flush, redirect_valid, trap_ecode, trap_esubcode, trap_era=pc, trap_badv=badv.
  - trap_is_tlbr=(ecode==0x3F).
  - redirect_pc = trap_is_tlbr ? csr_tlbrentry : csr_eentry.
- badv_we=1 for ecode in {0x1 PIL, 0x2 PIS, 0x3 PIF, 0x4 PME, 0x7 PPI, 0x8 ADE, 0x9 ALE, 0x3F TLBR}.
- vppn_we=1 for the same set excluding 0x8 and 0x9.
- ERTN event:
  - Drives ertn_we, flush and redirect_valid.
  - redirect_pc = csr_tlbr_active ? csr_tlbrera : csr_era.
  - trap_we=0.
- INT (ecode 0, exv=1) is a normal exception with no badv_we.
- flush_ack arriving in FIRE is registered and honoured: FIRE goes to IDLE after one DRAIN cycle at most.
- Slots with valid=0 are ignored regardless of exv or ertn.

Optional Feature:
- Macro: EXC_PERF_CNT_EN.
- Defined:
  - Adds outputs exc_cnt[31:0] and tlb_exc_cnt[31:0].
  - Both increment (wrapping) in FIRE; exc_cnt for any exception, tlb_exc_cnt when vppn_we.
  - Neither counts ERTN. Both reset to 0.
- Undefined: the counters and ports are absent.

Decomposition:
- Shared package/header holds the ecode and esubcode constants, with the EXP_* 7-bit codes composed from them.
- Shared package/header holds FSM state encodings IDLE/FIRE/DRAIN.
- One natural sub-module, exc_select: combinational slot arbitration. Outputs the chosen slot's pc, exp, badv and ertn flag, plus badv_we/vppn_we classification.

Test Plan:
- Slot0 valid, exv=1, exp=0x03 (PIF), pc=0x1C000100, badv=0x1C000100 -> next cycle:
  - trap_we=badv_we=vppn_we=flush=1, ecode=3.
  - redirect_pc=csr_eentry.
  - commit_stall=1 until flush_ack.
- Slot1 exp=0x3F (TLBR), slot0 clean -> trap_is_tlbr=1, redirect_pc=csr_tlbrentry, trap_era=pc1.
- Both slots except (slot0 ALE 0x09, slot1 PIL 0x01) -> only ALE taken: badv_we=1, vppn_we=0.
- Slot0 ERTN with csr_tlbr_active=1, tlbrera=0x1C002000 -> ertn_we=1, trap_we=0, redirect_pc=0x1C002000.
- Assert rst while in DRAIN -> all outputs 0 immediately, IDLE. Next event is processed normally.
- Commit events presented during DRAIN -> no pulses. With EXC_PERF_CNT_EN: exc_cnt increments exactly once per FIRE.
